regfile_multiport: RTL
======================

# regfile_multiport

Parametrised successor to the 32x64 dual-read register file: configurable depth, width and read-port count, a hardwired zero register, same-cycle write-to-read bypass, synchronous clear, and a per-register pending scoreboard for hazard detection. Sits in the decode stage of the CPU datapath. It feeds operand muxes and the hazard/stall unit, and is written from writeback.

## Interface
- `NUM_REG`, 32: number of registers (≥2).
- `REG_WIDTH`, 64: bits per register.
- `NUM_RD`, 2: number of independent read ports (≥1).
- `ZERO_REG`, 1: 1 = register `NUM_REG-1` always reads 0, ignores writes, never goes busy.
- `BYPASS`, 1: 1 = a write in the current cycle is forwarded to matching read ports in the same cycle.
- Derived: `AW = $clog2(NUM_REG)`.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high. Clears all registers and pending bits.
- `RegWrite`  in  1  write enable.
- `WriteRegister`  in  AW  write address.
- `WriteData`  in  REG_WIDTH  write value.
- `ReadRegister`  in  NUM_RD x AW  read address, one per port.
- `ReadData`  out  NUM_RD x REG_WIDTH  read value, one per port, combinational.
- `Reserve`  in  1  mark `ReserveRegister` pending (a producer is in flight).
- `ReserveRegister`  in  AW  register to reserve.
- `Busy`  out  NUM_RD  per port: the addressed register has an outstanding reservation.

## Operation
- Storage: `NUM_REG` x `REG_WIDTH` flops plus `NUM_REG` pending bits.
- Write: at the edge, if `RegWrite` is high and the address is valid, `mem[WriteRegister] <= WriteData` and `pending[WriteRegister] <= 0`.
- A write address is invalid when it is ≥ `NUM_REG`, or when it is the zero register with `ZERO_REG=1`. Invalid writes are ignored.
- Reserve: at the edge, if `Reserve` is high and `ReserveRegister` is valid, `pending[ReserveRegister] <= 1`.
- Reserve and write to the same register in the same cycle: the reserve wins and the pending bit ends at 1 (a new producer supersedes). The data write still happens.
- Read, per port p, in priority order:
  - Address invalid, or the zero register with `ZERO_REG=1`: `ReadData[p]` is 0.
  - Otherwise, if `BYPASS=1`, `RegWrite`, `WriteRegister == ReadRegister[p]` and `reset` is low: `ReadData[p] = WriteData`.
  - Otherwise: `ReadData[p] = mem[ReadRegister[p]]`.
- `Busy[p] = pending[ReadRegister[p]] & ~bypass_hit[p] & ~reset`.
  - `bypass_hit[p]` is the same-cycle write match above. The producer's result arrives this cycle, so the port is not busy.
  - With `BYPASS=0`, `bypass_hit` is always 0.
  - Zero-register and invalid addresses always give `Busy = 0`.
- Any number of read ports may address the same register. All see identical data and `Busy`.

## Timing
- Reset:
  - `reset` high at an edge clears every register and pending bit to 0.
  - `reset` overrides `RegWrite` and `Reserve` in that cycle.
  - While `reset` is high, bypass and `Busy` are suppressed; `ReadData` shows stored contents.
  - After the first reset edge, all `ReadData` and `Busy` outputs are 0.
- Write latency:
  - With `BYPASS=1`: 0 cycles (visible combinationally in the write cycle).
  - With `BYPASS=0`: 1 cycle (visible after the edge).
- Reserve latency: `Busy` rises the cycle after the `Reserve` edge.
- Reset mid-operation: all reservations are dropped. Writes in the reset cycle are lost.
- No combinational path from `Reserve` or `ReserveRegister` to any output.

## Structure
- Package `regfile_pkg`: default constants `REGFILE_NUM_REG=32` and `REGFILE_WIDTH=64`, plus the zero-register index constant for the 32-entry config. Shared with the decoder and the hazard unit.
- Sub-module `regfile_scoreboard` holds the pending bits.
  - Inputs: set (reserve), clear (write) and `reset`.
  - Output: per-port busy lookup.
  - The data array, bypass and read muxing stay in `regfile_multiport`.

## Test plan
1. Reset, then read all 32 registers on both ports: all `ReadData` = 0, `Busy` = 0.
2. Write X5 = 64'hCAFEBABEDEADBEEF with `ReadRegister[0]` = 5, `BYPASS=1`: `ReadData[0]` = CAFEBABEDEADBEEF in the write cycle. With `BYPASS=0`: old value 0 in that cycle, new value after the edge.
3. Write 64'hC0FFEE12380497CD to X31 (zero register), then read X31 on both ports: both read 0 and `Busy` = 0.
4. Reserve X16, then read X16: `Busy[0]` = 1 the next cycle. Write X16 = 64'h00000000000000A0: `Busy[0]` = 0 in the write cycle (bypass) and afterwards.
5. Reserve X7 and write X7 = 64'h1234 in the same cycle: afterwards X7 reads 64'h1234 and `Busy` = 1.
6. Write X3 = 64'hFFFF and reserve X4, then assert `reset` for 1 cycle with `RegWrite` = 1 to X3 = 64'h1: X3 = 0, `Busy` for X4 = 0. Also run `NUM_RD=4` with all ports on X3: identical outputs.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants for decode, hazard unit and datapath.
// Default geometry matches the 32 x 64 integer register file.
package regfile_pkg;

    localparam int REGFILE_NUM_REG = 32;
    localparam int REGFILE_WIDTH   = 64;
    localparam int REGFILE_AW      = $clog2(REGFILE_NUM_REG);

    localparam logic [REGFILE_AW-1:0] REGFILE_ZERO_IDX =
        REGFILE_AW'(REGFILE_NUM_REG - 1);

endpackage

// File: rtl/regfile_multiport_if.sv
// Register-file bus: writeback write port, reserve port, and read ports.
// master = decode/writeback side, slave = the register file.
interface regfile_multiport_if
    import regfile_pkg::*;
#(
    parameter int NUM_REG   = REGFILE_NUM_REG,
    parameter int REG_WIDTH = REGFILE_WIDTH,
    parameter int NUM_RD    = 2
);
    localparam int AW = $clog2(NUM_REG);

    logic                               RegWrite;
    logic [AW-1:0]                      WriteRegister;
    logic [REG_WIDTH-1:0]               WriteData;
    logic [NUM_RD-1:0][AW-1:0]          ReadRegister;
    logic [NUM_RD-1:0][REG_WIDTH-1:0]   ReadData;
    logic                               Reserve;
    logic [AW-1:0]                      ReserveRegister;
    logic [NUM_RD-1:0]                  Busy;

    modport master (
        output RegWrite, WriteRegister, WriteData,
        output ReadRegister, Reserve, ReserveRegister,
        input  ReadData, Busy
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData,
        input  ReadRegister, Reserve, ReserveRegister,
        output ReadData, Busy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits with per-port lookup.
// A set in the same cycle as a clear leaves the bit set.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REG = REGFILE_NUM_REG,
    parameter int NUM_RD  = 2,
    parameter int AW      = $clog2(NUM_REG)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      set,
    input  logic [AW-1:0]             set_addr,
    input  logic                      clr,
    input  logic [AW-1:0]             clr_addr,
    input  logic [NUM_RD-1:0][AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]         pend
);

    logic [NUM_REG-1:0] pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (clr) pending[clr_addr] <= 1'b0;
            if (set) pending[set_addr] <= 1'b1;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_pend
        assign pend[p] = pending[rd_addr[p]];
    end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file with zero register, write bypass and
// a pending scoreboard for decode-stage hazard detection.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int NUM_REG   = REGFILE_NUM_REG,
    parameter int REG_WIDTH = REGFILE_WIDTH,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic             clk,
    input  logic             reset,
    regfile_multiport_if.slave bus
);

    localparam int AW = $clog2(NUM_REG);
    localparam int NA = 1 << AW;

    // Addresses that name a real, writable register.
    function automatic logic [NA-1:0] valid_mask();
        logic [NA-1:0] m;
        for (int i = 0; i < NA; i++) begin
            m[i] = (i < NUM_REG) && !(ZERO_REG != 0 && i == NUM_REG - 1);
        end
        return m;
    endfunction

    localparam logic [NA-1:0] VMASK = valid_mask();

    logic [REG_WIDTH-1:0] mem [NUM_REG];
    logic                 wr_ok;
    logic                 rsv_ok;
    logic [NUM_RD-1:0]    pend;

    assign wr_ok  = bus.RegWrite & VMASK[bus.WriteRegister];
    assign rsv_ok = bus.Reserve & VMASK[bus.ReserveRegister];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[bus.WriteRegister] <= bus.WriteData;
        end
    end

    regfile_scoreboard #(
        .NUM_REG (NUM_REG),
        .NUM_RD  (NUM_RD),
        .AW      (AW)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set      (rsv_ok),
        .set_addr (bus.ReserveRegister),
        .clr      (wr_ok),
        .clr_addr (bus.WriteRegister),
        .rd_addr  (bus.ReadRegister),
        .pend     (pend)
    );

    logic [NUM_RD-1:0][REG_WIDTH-1:0] rdata;
    logic [NUM_RD-1:0]                busy;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] a;
        logic          ok;
        logic          hit;

        assign a   = bus.ReadRegister[p];
        assign ok  = VMASK[a];
        assign hit = (BYPASS != 0) && bus.RegWrite &&
                     (bus.WriteRegister == a) && !reset;

        assign rdata[p] = !ok ? '0 :
                          hit ? bus.WriteData : mem[a];
        assign busy[p]  = ok & pend[p] & ~hit & ~reset;
    end

    assign bus.ReadData = rdata;
    assign bus.Busy     = busy;

endmodule
